// File: rtl/inst_fetch_unit.sv
// Instruction fetch: in-order imem requests, prefetch FIFO, redirect flush.
// Head instruction and its Op/F3/F7 slices feed the decode controller.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  Op,
  output logic [2:0]  F3,
  output logic [6:0]  F7,
  input  logic        inst_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] dis_q, dis_d;
  logic [AW-1:0] hd_q, hd_d;
  logic [AW-1:0] tl_q, tl_d;
  logic [AW-1:0] trp_q, trp_d;
  logic [AW-1:0] twp_q, twp_d;

  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] w_mem   [DEPTH];
  logic [31:0] tag_mem [DEPTH];

  logic [CW:0] live;
  logic        xfer;
  logic        resp;
  logic        wr;
  logic        pop;

  // in-flight requests already marked for discard do not hold FIFO space
  assign live = {1'b0, occ_q} + {1'b0, out_q} - {1'b0, dis_q};

  assign imem_req = (state_q == RUN)
                 && (live < (CW+1)'(DEPTH))
                 && (out_q < CW'(DEPTH));
  assign imem_addr = fpc_q;

  assign xfer = imem_req & imem_gnt;
  assign resp = imem_rvalid && (out_q != '0);
  assign wr   = resp && (dis_q == '0) && !redirect;
  assign pop  = inst_ack && inst_valid && !redirect;

  assign inst_valid = (occ_q != '0);
  assign inst    = inst_valid ? w_mem[hd_q] : 32'h0000_0013;
  assign inst_pc = inst_valid ? pc_mem[hd_q] : 32'h0;
  assign Op = inst[6:0];
  assign F3 = inst[14:12];
  assign F7 = inst[31:25];

  always_comb begin
    state_d = RUN;
    fpc_d   = fpc_q;
    out_d   = out_q + CW'(xfer) - CW'(resp);
    occ_d   = occ_q + CW'(wr) - CW'(pop);
    dis_d   = dis_q;
    hd_d    = hd_q + AW'(pop);
    tl_d    = tl_q + AW'(wr);
    twp_d   = twp_q + AW'(xfer);
    trp_d   = trp_q + AW'(resp);
    if (xfer) begin
      fpc_d = fpc_q + 32'd4;
    end
    if (resp && (dis_q != '0)) begin
      dis_d = dis_q - CW'(1);
    end
    // tags stay queued so stale responses still pop their own entry
    if (redirect) begin
      fpc_d = redirect_pc & ~32'h3;
      occ_d = '0;
      hd_d  = '0;
      tl_d  = '0;
      dis_d = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      occ_q   <= '0;
      out_q   <= '0;
      dis_q   <= '0;
      hd_q    <= '0;
      tl_q    <= '0;
      trp_q   <= '0;
      twp_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      occ_q   <= occ_d;
      out_q   <= out_d;
      dis_q   <= dis_d;
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      trp_q   <= trp_d;
      twp_q   <= twp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[tl_q] <= tag_mem[trp_q];
      w_mem[tl_q]  <= imem_rdata;
    end
    if (xfer) begin
      tag_mem[twp_q] <= fpc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a variable-latency memory model.
// Memory returns (address ^ xorpat) in request order.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  Op;
  logic [2:0]  F3;
  logic [6:0]  F7;
  logic        inst_ack;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vecs;
  int errs;
  int cyc;
  int lat;
  logic [31:0] xorpat;
  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] xlog   [$];

  inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .Op(Op), .F3(F3), .F7(F7),
    .inst_ack(inst_ack), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // one clock: log the transfer, then present any due response
  task automatic step();
    logic        x;
    logic [31:0] a;
    x = imem_req & imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (x) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat - 1);
      xlog.push_back(a);
    end
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = q_addr[0] ^ xorpat;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // leaves the DUT in its BOOT cycle
  task automatic do_reset();
    rst = 1'b0;
    q_addr.delete();
    q_due.delete();
    xlog.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_gnt    = 1'b1;
    inst_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat    = 1;
    xorpat = 32'h0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    step();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %h exp 0", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %h exp 0", inst_valid); end
    vecs++; if (inst !== 32'h13) begin errs++; $display("FAIL rst_inst got %h exp 13", inst); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
    vecs++; if (Op !== 7'h13) begin errs++; $display("FAIL rst_op got %h exp 13", Op); end
    vecs++; if (F3 !== 3'h0) begin errs++; $display("FAIL rst_f3 got %h exp 0", F3); end
    vecs++; if (F7 !== 7'h0) begin errs++; $display("FAIL rst_f7 got %h exp 0", F7); end
    rst = 1'b1;
    #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL boot_req got %h exp 0", imem_req); end
    step();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL run_req got %h exp 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL run_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] ew;
    do_reset();
    step();
    inst_ack = 1'b1;
    step();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL stream_early got %h exp 0", inst_valid); end
    vecs++; if (imem_addr !== 32'h4) begin errs++; $display("FAIL stream_addr got %h exp 4", imem_addr); end
    for (int k = 0; k < 8; k++) begin
      step();
      ew = 32'(k * 4);
      vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL stream_valid k=%0d got %h exp 1", k, inst_valid); end
      vecs++; if (inst !== ew) begin errs++; $display("FAIL stream_inst k=%0d got %h exp %h", k, inst, ew); end
      vecs++; if (inst_pc !== ew) begin errs++; $display("FAIL stream_pc k=%0d got %h exp %h", k, inst_pc, ew); end
      vecs++; if (Op !== ew[6:0]) begin errs++; $display("FAIL stream_op k=%0d got %h exp %h", k, Op, ew[6:0]); end
    end
    inst_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ea;
    do_reset();
    step();
    xlog.delete();
    repeat (8) step();
    vecs++; if (xlog.size() !== 4) begin errs++; $display("FAIL bp_count got %0d exp 4", xlog.size()); end
    for (int i = 0; i < 4 && i < xlog.size(); i++) begin
      ea = 32'(i * 4);
      vecs++; if (xlog[i] !== ea) begin errs++; $display("FAIL bp_addr i=%0d got %h exp %h", i, xlog[i], ea); end
    end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_req_full got %h exp 0", imem_req); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL bp_head got %h exp 0", inst_pc); end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL bp_req_ack got %h exp 1", imem_req); end
    vecs++; if (imem_addr !== 32'h10) begin errs++; $display("FAIL bp_addr_ack got %h exp 10", imem_addr); end
    vecs++; if (inst_pc !== 32'h4) begin errs++; $display("FAIL bp_head2 got %h exp 4", inst_pc); end
    repeat (6) step();
    vecs++; if (xlog.size() !== 5) begin errs++; $display("FAIL bp_count2 got %0d exp 5", xlog.size()); end
    if (xlog.size() >= 5) begin
      vecs++; if (xlog[4] !== 32'h10) begin errs++; $display("FAIL bp_addr5 got %h exp 10", xlog[4]); end
    end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_req_end got %h exp 0", imem_req); end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    step();
    xorpat = 32'hA5A5_5A5A;
    step();
    imem_gnt = 1'b0;
    step();
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL rd_pre_valid got %h exp 1", inst_valid); end
    lat = 3;
    imem_gnt = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rd_flush got %h exp 0", inst_valid); end
    vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rd_addr got %h exp 100", imem_addr); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rd_req got %h exp 1", imem_req); end
    n = 0;
    while (!inst_valid && n < 12) begin
      step();
      n++;
    end
    vecs++; if (n !== 4) begin errs++; $display("FAIL rd_wait got %0d exp 4", n); end
    vecs++; if (inst_pc !== 32'h100) begin errs++; $display("FAIL rd_pc got %h exp 100", inst_pc); end
    vecs++; if (inst !== 32'hA5A5_5B5A) begin errs++; $display("FAIL rd_inst got %h exp a5a55b5a", inst); end
    vecs++; if (Op !== 7'h5A) begin errs++; $display("FAIL rd_op got %h exp 5a", Op); end
    vecs++; if (F3 !== 3'h5) begin errs++; $display("FAIL rd_f3 got %h exp 5", F3); end
    vecs++; if (F7 !== 7'h52) begin errs++; $display("FAIL rd_f7 got %h exp 52", F7); end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    vecs++; if (inst_pc !== 32'h104) begin errs++; $display("FAIL rd_pc2 got %h exp 104", inst_pc); end
    vecs++; if (inst !== 32'hA5A5_5B5E) begin errs++; $display("FAIL rd_inst2 got %h exp a5a55b5e", inst); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step();
    step();
    step();
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL sc_pre_valid got %h exp 1", inst_valid); end
    vecs++; if (imem_rvalid !== 1'b1) begin errs++; $display("FAIL sc_pre_rvalid got %h exp 1", imem_rvalid); end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    inst_ack = 1'b1;
    step();
    redirect = 1'b0;
    inst_ack = 1'b0;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL sc_flush got %h exp 0", inst_valid); end
    vecs++; if (imem_addr !== 32'h200) begin errs++; $display("FAIL sc_addr got %h exp 200", imem_addr); end
    step();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL sc_stale got %h exp 0", inst_valid); end
    step();
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL sc_valid got %h exp 1", inst_valid); end
    vecs++; if (inst_pc !== 32'h200) begin errs++; $display("FAIL sc_pc got %h exp 200", inst_pc); end
    vecs++; if (inst !== 32'h200) begin errs++; $display("FAIL sc_inst got %h exp 200", inst); end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    vecs++; if (inst_pc !== 32'h204) begin errs++; $display("FAIL sc_pc2 got %h exp 204", inst_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL wr_req got %h exp 1", imem_req); end
    vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_boot_addr got %h exp fffffffc", imem_addr); end
    step();
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL wr_wrap got %h exp 0", imem_addr); end
    step();
    vecs++; if (inst_pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_pc got %h exp fffffffc", inst_pc); end
    inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL wr_pc2 got %h exp 0", inst_pc); end
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL wr_valid2 got %h exp 1", inst_valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    step();
    step();
    lat = 3;
    step();
    step();
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL rm_pre_valid got %h exp 1", inst_valid); end
    rst = 1'b0;
    #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rm_valid got %h exp 0", inst_valid); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rm_req got %h exp 0", imem_req); end
    step();
    rst = 1'b1;
    step();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rm_req2 got %h exp 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rm_addr got %h exp 0", imem_addr); end
    step();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rm_late got %h exp 0", inst_valid); end
    vecs++; if (imem_addr !== 32'h4) begin errs++; $display("FAIL rm_addr2 got %h exp 4", imem_addr); end
    n = 1;
    while (!inst_valid && n < 12) begin
      step();
      n++;
    end
    vecs++; if (n !== 4) begin errs++; $display("FAIL rm_wait got %0d exp 4", n); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL rm_pc got %h exp 0", inst_pc); end
    vecs++; if (inst !== 32'h0) begin errs++; $display("FAIL rm_inst got %h exp 0", inst); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc  = 0;
    lat  = 1;
    xorpat = 32'h0;
    rst = 1'b0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    inst_ack = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
